// File: rtl/iob_gpio_sseg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module : iob_gpio_sseg_scan_pkg
// Desc   : Shared state encoding and counter-width helper for the scanner.
// Rev    : 1.0  initial release
// ============================================================================
package iob_gpio_sseg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ON    = 2'd2,
    ST_BLANK = 2'd3
  } sseg_state_t;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_gpio_sseg_slot_timer.sv
`default_nettype none
// ============================================================================
// Module : iob_gpio_sseg_slot_timer
// Desc   : Per-digit slot counter and digit index with slot/frame end flags.
// Rev    : 1.0  initial release
// ============================================================================
module iob_gpio_sseg_slot_timer
  import iob_gpio_sseg_scan_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned CNT_W    = cnt_width(PRESCALE),
  parameter int unsigned IDX_W    = cnt_width(N_DIGITS)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_run,
  output logic [CNT_W-1:0] o_slot_cnt,
  output logic [IDX_W-1:0] o_digit_nxt,
  output logic             o_slot_end,
  output logic             o_frame_end
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0] r_slot_cnt;
  logic [IDX_W-1:0] r_digit_idx;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_idx_nxt;

  assign o_slot_end  = (r_slot_cnt == C_CNT_LAST);
  assign o_frame_end = o_slot_end && (r_digit_idx == C_IDX_LAST);
  assign o_slot_cnt  = r_slot_cnt;
  assign o_digit_nxt = w_idx_nxt;

  // Counters collapse to zero whenever the scan is not in a lit/dark slot.
  always_comb begin
    w_cnt_nxt = '0;
    w_idx_nxt = '0;
    if (i_run) begin
      if (o_slot_end) begin
        w_idx_nxt = (r_digit_idx == C_IDX_LAST) ? '0 : r_digit_idx + 1'b1;
      end else begin
        w_cnt_nxt = r_slot_cnt + 1'b1;
        w_idx_nxt = r_digit_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
    end else begin
      r_slot_cnt  <= w_cnt_nxt;
      r_digit_idx <= w_idx_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/iob_gpio_sseg_scan.sv
`default_nettype none
// ============================================================================
// Module : iob_gpio_sseg_scan
// Desc   : Time-multiplexed seven-segment scanner with PWM brightness.
// Rev    : 1.0  initial release
// ============================================================================
module iob_gpio_sseg_scan
  import iob_gpio_sseg_scan_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SEG_W        = 8,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      en,
  input  logic [N_DIGITS*SEG_W-1:0] seg_pattern,
  input  logic [7:0]                brightness,
  output logic [SEG_W-1:0]          seg_out,
  output logic [N_DIGITS-1:0]       an_out,
  output logic                      frame_done
);

  localparam int unsigned C_CNT_W  = cnt_width(PRESCALE);
  localparam int unsigned C_IDX_W  = cnt_width(N_DIGITS);
  localparam int unsigned C_PROD_W = C_CNT_W + 9;
  localparam logic [C_PROD_W-1:0] C_SPAN = C_PROD_W'(PRESCALE - BLANK_CYCLES);

  sseg_state_t               r_state;
  sseg_state_t               w_state_nxt;
  logic [N_DIGITS*SEG_W-1:0] r_seg_shadow;
  logic [C_CNT_W-1:0]        r_on_len;
  logic [C_CNT_W-1:0]        w_on_len;
  logic [C_PROD_W-1:0]       w_bright_p1;
  logic [C_CNT_W-1:0]        w_slot_cnt;
  logic [C_IDX_W-1:0]        w_digit_nxt;
  logic                      w_slot_end;
  logic                      w_frame_end;
  logic                      w_run;
  logic                      w_on_last;
  logic [N_DIGITS*SEG_W-1:0] w_seg_src;
  logic [SEG_W-1:0]          w_slice;
  logic [SEG_W-1:0]          w_seg_nxt;
  logic [N_DIGITS-1:0]       w_an_nxt;
  logic [SEG_W-1:0]          r_seg_out;
  logic [N_DIGITS-1:0]       r_an_out;
  logic                      r_frame_done;

  assign w_bright_p1 = C_PROD_W'({1'b0, brightness}) + C_PROD_W'(1);
  assign w_on_len    = C_CNT_W'((C_SPAN * w_bright_p1) >> 8);
  assign w_run       = en && ((r_state == ST_ON) || (r_state == ST_BLANK));
  assign w_on_last   = (w_slot_cnt == r_on_len - 1'b1);

  iob_gpio_sseg_slot_timer #(
    .N_DIGITS (N_DIGITS),
    .PRESCALE (PRESCALE),
    .CNT_W    (C_CNT_W),
    .IDX_W    (C_IDX_W)
  ) u_slot_timer (
    .clk         (clk),
    .arst_n      (arst_n),
    .i_run       (w_run),
    .o_slot_cnt  (w_slot_cnt),
    .o_digit_nxt (w_digit_nxt),
    .o_slot_end  (w_slot_end),
    .o_frame_end (w_frame_end)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (en) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = (w_on_len == '0) ? ST_BLANK : ST_ON;
      ST_ON:    if (w_on_last) w_state_nxt = ST_BLANK;
      ST_BLANK: begin
        if (w_frame_end) begin
          w_state_nxt = ST_LOAD;
        end else if (w_slot_end) begin
          // A zero duty keeps every slot dark instead of flashing one cycle.
          w_state_nxt = (r_on_len == '0) ? ST_BLANK : ST_ON;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (!en) w_state_nxt = ST_IDLE;
  end

  // During LOAD the shadow is being written, so digit 0 reads the live word.
  assign w_seg_src = (r_state == ST_LOAD) ? seg_pattern : r_seg_shadow;
  assign w_slice   = w_seg_src[w_digit_nxt*SEG_W +: SEG_W];

  always_comb begin
    w_seg_nxt = '1;
    w_an_nxt  = '1;
    if (w_state_nxt == ST_ON) begin
      w_seg_nxt = ~w_slice;
      w_an_nxt  = ~(N_DIGITS'(1) << w_digit_nxt);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= ST_IDLE;
      r_seg_shadow <= '0;
      r_on_len     <= '0;
      r_seg_out    <= '1;
      r_an_out     <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      if (r_state == ST_LOAD) begin
        r_seg_shadow <= seg_pattern;
        r_on_len     <= w_on_len;
      end
      r_seg_out    <= w_seg_nxt;
      r_an_out     <= w_an_nxt;
      r_frame_done <= (w_state_nxt == ST_LOAD) && (r_state == ST_BLANK);
    end
  end

  assign seg_out    = r_seg_out;
  assign an_out     = r_an_out;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
